// File: rtl/imem_readback_if.sv
// Bus bundle for the instruction-memory readback engine:
// memory read port plus the byte stream toward the port-b pads.
interface imem_readback_if #(
    parameter int ADR_W  = 10,
    parameter int DATA_W = 40
);
    logic              imem_rd_en;
    logic [ADR_W-1:0]  imem_rd_adr;
    logic [DATA_W-1:0] imem_rd_data;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output imem_rd_en, imem_rd_adr, out_byte, out_valid,
        input  imem_rd_data, out_ready
    );

    modport slave (
        input  imem_rd_en, imem_rd_adr, out_byte, out_valid,
        output imem_rd_data, out_ready
    );
endinterface

// File: rtl/imem_readback.sv
// Reads a run of instruction words and streams each as an
// MSB-first {address, data} byte frame, replayable by the loader.
module imem_readback #(
    parameter int ADR_W  = 10,
    parameter int DATA_W = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [ADR_W-1:0] rd_adr,
    input  logic [ADR_W-1:0] rd_len,
    imem_readback_if.master  bus,
    output logic             busy,
    output logic             done
);
    localparam int NBYTES = (ADR_W + DATA_W + 7) / 8;
    localparam int FW     = NBYTES * 8;
    localparam int IDX_W  = $clog2(NBYTES + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, READ, LOAD, SEND} state_t;

    state_t            state_q, state_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [ADR_W-1:0]  wcnt_q, wcnt_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            adr_q   <= '0;
            wcnt_q  <= '0;
            frame_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            wcnt_q  <= wcnt_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        wcnt_d  = wcnt_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        // Abort wins over a byte transfer in the same cycle.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        adr_d   = rd_adr;
                        wcnt_d  = rd_len;
                        state_d = READ;
                    end
                end
                READ: state_d = LOAD;
                LOAD: begin
                    frame_d = FW'({adr_q, bus.imem_rd_data});
                    idx_d   = '0;
                    state_d = SEND;
                end
                SEND: begin
                    if (bus.out_ready) begin
                        // Frame shifts left so the top byte is always next out.
                        frame_d = frame_q << 8;
                        if (idx_q == LAST) begin
                            if (wcnt_q == '0) begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end else begin
                                wcnt_d  = wcnt_q - 1'b1;
                                adr_d   = adr_q + 1'b1;
                                state_d = READ;
                            end
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign bus.imem_rd_en  = (state_q == READ);
    assign bus.imem_rd_adr = adr_q;
    assign bus.out_valid   = (state_q == SEND);
    assign bus.out_byte    = (state_q == SEND) ? frame_q[FW-1 -: 8] : 8'h00;
endmodule

// File: tb/tb_imem_readback.sv
// Directed bench for imem_readback with a queue-based frame model
// checked every cycle, plus literal byte/latency expectations.
module tb_imem_readback;
    localparam int AW = 10;
    localparam int DW = 40;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] rd_adr = '0;
    logic [AW-1:0] rd_len = '0;
    logic          busy, done;

    imem_readback_if #(.ADR_W(AW), .DATA_W(DW)) bus ();

    imem_readback #(.ADR_W(AW), .DATA_W(DW)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .abort  (abort),
        .rd_adr (rd_adr),
        .rd_len (rd_len),
        .bus    (bus),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:1023];
    always @(posedge clk)
        if (bus.imem_rd_en) bus.imem_rd_data <= mem[bus.imem_rd_adr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs = 0;
    int errs = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic bad(string nm, logic [63:0] act);
        vecs++;
        errs++;
        $display("FAIL %s: got %0h want nothing", nm, act);
    endtask

    function automatic logic [7:0] fbyte(logic [AW-1:0] a,
                                         logic [DW-1:0] d, int i);
        logic [55:0] f;
        f = {6'b0, a, d};
        f = f >> (8 * (6 - i));
        return f[7:0];
    endfunction

    logic [7:0]    m_bytes [$];
    logic [AW-1:0] m_rd [$];
    logic [7:0]    got [$];
    int            got_cyc [$];
    int            rd_cyc [$];
    bit            m_busy = 0, m_done = 0, m_stall = 0, chk_en = 0;
    logic [7:0]    stall_byte = '0;
    int            st_cyc = 0, done_cyc = 0, n_done = 0;

    task automatic flush();
        m_bytes.delete();
        m_rd.delete();
        m_busy  = 0;
        m_done  = 0;
        m_stall = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (reset) begin
                flush();
            end else begin
                chk("busy", busy, m_busy);
                chk("done", done, m_done);
                if (done) begin
                    n_done++;
                    done_cyc = cyc;
                end
                if (m_stall) begin
                    chk("hold_valid", bus.out_valid, 1'b1);
                    chk("hold_byte", bus.out_byte, stall_byte);
                end
                if (!m_busy) begin
                    chk("idle_valid", bus.out_valid, 1'b0);
                    chk("idle_rd_en", bus.imem_rd_en, 1'b0);
                end else if (bus.imem_rd_en) begin
                    rd_cyc.push_back(cyc);
                    if (m_rd.size() == 0) bad("rd_extra", bus.imem_rd_adr);
                    else chk("rd_adr", bus.imem_rd_adr, m_rd.pop_front());
                end
                m_done  = 0;
                m_stall = 0;
                if (abort && m_busy) begin
                    flush();
                end else if (start && !m_busy) begin
                    for (int w = 0; w <= int'(rd_len); w++) begin
                        logic [AW-1:0] a;
                        a = rd_adr + AW'(w);
                        m_rd.push_back(a);
                        for (int i = 0; i < 7; i++)
                            m_bytes.push_back(fbyte(a, mem[a], i));
                    end
                    m_busy = 1;
                    st_cyc = cyc;
                end else if (m_busy && bus.out_valid) begin
                    if (!bus.out_ready) begin
                        m_stall    = 1;
                        stall_byte = bus.out_byte;
                    end else if (m_bytes.size() == 0) begin
                        bad("byte_extra", bus.out_byte);
                    end else begin
                        chk("byte", bus.out_byte, m_bytes.pop_front());
                        got.push_back(bus.out_byte);
                        got_cyc.push_back(cyc);
                        if (m_bytes.size() == 0) begin
                            m_done = 1;
                            m_busy = 0;
                        end
                    end
                end
            end
        end
    end

    bit rnd = 0;

    task automatic tick();
        @(posedge clk);
        #2;
        if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic go(logic [AW-1:0] a, logic [AW-1:0] l);
        got.delete();
        got_cyc.delete();
        rd_cyc.delete();
        rd_adr = a;
        rd_len = l;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) bad("idle_timeout", busy);
        tick();
    endtask

    task automatic wait_bytes(int n);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (got.size() >= n) begin
                ok = 1;
                break;
            end
        end
        if (!ok) bad("byte_timeout", got.size());
    endtask

    logic [7:0] e1 [7] = '{8'h03, 8'hA5, 8'h12, 8'h34,
                           8'h56, 8'h78, 8'h9A};
    int nd0;

    initial begin
        for (int i = 0; i < 1024; i++)
            mem[i] = {8'(i), 32'(i * 32'h9E37_79B1)};
        mem['h3A5] = 40'h12_3456_789A;
        mem['h3FF] = 40'hDE_ADBE_EF01;
        mem['h000] = 40'h01_0203_0405;
        bus.out_ready = 1'b1;

        #1 reset = 1'b1;
        #1;
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_rd_en", bus.imem_rd_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_byte", bus.out_byte, 8'h00);
        chk("rst_adr", bus.imem_rd_adr, 10'h000);
        tick();
        tick();
        reset  = 1'b0;
        chk_en = 1;
        tick();

        // Single word, ready held high: exact bytes and latency.
        go(10'h3A5, 10'd0);
        wait_idle();
        chk("t1_count", got.size(), 7);
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            chk("t1_byte", got[i], e1[i]);
            chk("t1_bcyc", 64'(got_cyc[i] - st_cyc), 64'(3 + i));
        end
        if (rd_cyc.size() > 0) chk("t1_rdcyc", 64'(rd_cyc[0] - st_cyc), 1);
        else bad("t1_no_read", 0);
        chk("t1_donecyc", 64'(done_cyc - st_cyc), 10);

        // Two words across the address wrap, one done pulse.
        nd0 = n_done;
        go(10'h3FF, 10'd1);
        wait_idle();
        chk("t2_count", got.size(), 14);
        if (got.size() == 14) begin
            chk("t2_b0", got[0], 8'h03);
            chk("t2_b1", got[1], 8'hFF);
            chk("t2_b2", got[2], 8'hDE);
            chk("t2_b7", got[7], 8'h00);
            chk("t2_b8", got[8], 8'h00);
            chk("t2_b9", got[9], 8'h01);
        end
        if (rd_cyc.size() == 2) chk("t2_w2w", 64'(rd_cyc[1] - rd_cyc[0]), 9);
        else bad("t2_reads", rd_cyc.size());
        chk("t2_dones", 64'(n_done - nd0), 1);

        // Random back-pressure, four words.
        rnd = 1;
        go(10'h0F0, 10'd3);
        wait_idle();
        rnd = 0;
        bus.out_ready = 1'b1;
        chk("t3_count", got.size(), 28);

        // Ignored start while busy, then abort during byte 3.
        nd0 = n_done;
        go(10'h010, 10'd2);
        tick();
        rd_adr = 10'h200;
        rd_len = 10'd0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        wait_bytes(3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_valid", bus.out_valid, 1'b0);
        chk("t4_busy", busy, 1'b0);
        chk("t4_count", got.size(), 3);
        tick();
        tick();
        chk("t4_dones", 64'(n_done - nd0), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_idle_abort", busy, 1'b0);

        // Asynchronous reset mid-frame, then a clean restart.
        go(10'h155, 10'd0);
        wait_bytes(2);
        #1 reset = 1'b1;
        #1;
        chk("t5_valid", bus.out_valid, 1'b0);
        chk("t5_rd_en", bus.imem_rd_en, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_done", done, 1'b0);
        chk("t5_byte", bus.out_byte, 8'h00);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("t5_stay_idle", busy, 1'b0);
        go(10'h155, 10'd0);
        wait_idle();
        chk("t5_count", got.size(), 7);
        if (got.size() == 7) begin
            chk("t5_b0", got[0], 8'h01);
            chk("t5_b1", got[1], 8'h55);
            chk("t5_b2", got[2], 8'h55);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/imem_readback.md
IMEM_READBACK -- requirements
Module: imem_readback

Interface
REQ-001 SHALL have parameter ADR_W, default 10, instruction-memory address width.
REQ-002 SHALL have parameter DATA_W, default 40, instruction word width; frame = ADR_W+DATA_W bits padded to NBYTES = ceil((ADR_W+DATA_W)/8) = 7 at defaults.
REQ-003 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request readback; sampled only in IDLE.
REQ-006 abort  in  1  cancel transfer in progress.
REQ-007 rd_adr  in  ADR_W  first word address.
REQ-008 rd_len  in  ADR_W  word count minus one (0 -> 1 word, 1023 -> 1024 words).
REQ-009 imem_rd_en  out  1  instruction-memory read strobe.
REQ-010 imem_rd_adr  out  ADR_W  instruction-memory read address.
REQ-011 imem_rd_data  in  DATA_W  read data, valid the cycle after imem_rd_en.
REQ-012 out_byte  out  8  byte toward port-b pads.
REQ-013 out_valid  out  1  out_byte valid.
REQ-014 out_ready  in  1  consumer accepts byte.
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 done  out  1  one-cycle pulse after last byte of last word accepted.

Function
REQ-017 SHALL implement FSM IDLE, READ, LOAD, SEND.
REQ-018 IDLE: start=1 latches rd_adr into address counter, rd_len into word counter, next state READ.
REQ-019 READ (1 cycle): imem_rd_en=1, imem_rd_adr=address counter; next LOAD.
REQ-020 LOAD (1 cycle): frame register loaded with {pad zeros, address counter, imem_rd_data}, byte index cleared; next SEND.
REQ-021 Frame byte order SHALL be MSB-first: byte0 = {6'b0, adr[9:8]}, byte1 = adr[7:0], byte2..byte6 = data[39:32]..data[7:0], matching the port-a write-loader shift order so a captured stream replays unchanged.
REQ-022 SEND: out_valid=1, out_byte = current frame byte; byte transfers on rising edge with out_valid&out_ready.
REQ-023 out_byte SHALL stay stable while out_valid=1 and out_ready=0; out_valid SHALL NOT drop without a transfer except on abort/reset.
REQ-024 After byte NBYTES-1 transfers: word counter 0 -> done=1 next cycle, state IDLE; else word counter decrements, address counter increments, state READ.
REQ-025 Address counter SHALL wrap 2^ADR_W-1 -> 0.
REQ-026 Latency: start sampled at edge n -> imem_rd_en high cycle n+1 -> out_valid high cycle n+3; word-to-word minimum 9 cycles with out_ready held 1.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE next edge, out_valid=0, no done pulse; abort has priority over byte transfer in the same cycle; abort in IDLE has no effect.
REQ-029 imem_rd_en SHALL be 0 outside READ; imem_rd_adr holds address counter at all times.

Reset
REQ-030 reset=1 SHALL asynchronously force IDLE, out_valid=0, imem_rd_en=0, busy=0, done=0, out_byte=0, counters and frame register 0.
REQ-031 Reset mid-frame SHALL discard the frame; first transfer after release requires new start.

Verification
REQ-032 start, rd_adr=0x3A5, rd_len=0, mem[0x3A5]=0x12_3456_789A, out_ready=1 -> rd_en at n+1, bytes 03,A5,12,34,56,78,9A on cycles n+3..n+9, done at n+10.
REQ-033 rd_adr=0x3FF, rd_len=1 -> reads 0x3FF then 0x000; second frame starts 03,FF... no, bytes 00,00 then data; one done pulse.
REQ-034 out_ready toggled randomly -> out_byte constant while stalled, no byte lost or duplicated, 7 transfers per word.
REQ-035 abort asserted during byte 3 with out_ready=1 -> out_valid 0 next cycle, no done, busy 0; start during busy ignored.
REQ-036 reset asserted mid-SEND between clock edges -> outputs reach reset values immediately; subsequent start produces full correct frame.
